// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG word source: word width, serve FSM states,
// default repetition-count cutoff.
package trng_pkg;

  localparam int TRNG_WORD_W        = 32;
  localparam int TRNG_BIT_CNT_W     = $clog2(TRNG_WORD_W);
  localparam int RCT_CUTOFF_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE,
    S_GAP,
    S_FAIL
  } trng_srv_state_t;

endpackage

// File: rtl/trng_word_fifo.sv
// Synchronous word FIFO with flush. Push and pop may coincide in any state;
// there is no bypass from push to pop.
module trng_word_fifo
  import trng_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [TRNG_WORD_W-1:0]   push_data,
  input  logic                     pop,
  output logic [TRNG_WORD_W-1:0]   pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [TRNG_WORD_W-1:0] mem_q [DEPTH];
  logic                   push_en, pop_en;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign pop_en   = pop && !empty;
  // A pop frees the slot a same-cycle push needs when full.
  assign push_en  = push && (!full || pop_en);
  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/trng_word_source.sv
// TRNG word source: von Neumann debias, 32-bit LSB-first packer, word FIFO and
// request/ready serve FSM. Define TRNG_HEALTH_TEST_EN to add the repetition-count health test.
module trng_word_source
  import trng_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ent_bit,
  input  logic                        ent_valid,
  input  logic                        trng_request,
  output logic                        trng_ready,
  output logic [TRNG_WORD_W-1:0]      trng_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        health_fail
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RCT_CUTOFF < 2) begin : g_param_check
    $error("trng_word_source: FIFO_DEPTH must be a power of 2 >= 2 and RCT_CUTOFF >= 2");
  end

  logic                      flush;
  logic                      have_first_q, have_first_d;
  logic                      first_q, first_d;
  logic [TRNG_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TRNG_WORD_W-1:0]    word_q, word_d;
  logic                      word_held_q, word_held_d;
  logic                      push;
  logic [TRNG_WORD_W-1:0]    push_word;
  logic                      pop;
  logic                      fifo_full, fifo_empty;
  logic [TRNG_WORD_W-1:0]    fifo_rdata;
  trng_srv_state_t           state_q, state_d;
  logic [TRNG_WORD_W-1:0]    data_q, data_d;

  // Debias and pack: the surviving bit of an unequal pair is always the first one.
  always_comb begin
    have_first_d = have_first_q;
    first_d      = first_q;
    bit_cnt_d    = bit_cnt_q;
    word_d       = word_q;
    word_held_d  = word_held_q;
    push         = 1'b0;
    push_word    = word_q;
    if (word_held_q) begin
      if (!fifo_full) begin
        push        = 1'b1;
        word_held_d = 1'b0;
      end
    end else if (ent_valid) begin
      if (!have_first_q) begin
        have_first_d = 1'b1;
        first_d      = ent_bit;
      end else begin
        have_first_d = 1'b0;
        if (first_q != ent_bit) begin
          word_d[bit_cnt_q] = first_q;
          push_word         = word_d;
          if (bit_cnt_q == TRNG_BIT_CNT_W'(TRNG_WORD_W - 1)) begin
            bit_cnt_d = '0;
            if (!fifo_full) push = 1'b1;
            else            word_held_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + TRNG_BIT_CNT_W'(1);
          end
        end
      end
    end
    if (flush) begin
      have_first_d = 1'b0;
      bit_cnt_d    = '0;
      word_held_d  = 1'b0;
      push         = 1'b0;
    end
  end

  trng_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Serve FSM: the GAP state gives the consumer a cycle to drop its request.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trng_request && !fifo_empty) begin
          pop     = 1'b1;
          state_d = S_SERVE;
        end
      end
      S_SERVE: state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef TRNG_HEALTH_TEST_EN
    if (flush) begin
      pop     = 1'b0;
      state_d = S_FAIL;
    end
`endif
    data_d = pop ? fifo_rdata : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      have_first_q <= 1'b0;
      bit_cnt_q    <= '0;
      word_held_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      have_first_q <= have_first_d;
      bit_cnt_q    <= bit_cnt_d;
      word_held_q  <= word_held_d;
    end
  end

  always_ff @(posedge clk) begin
    first_q <= first_d;
    word_q  <= word_d;
  end

  assign trng_ready = (state_q == S_SERVE);
  assign trng_data  = data_q;

`ifdef TRNG_HEALTH_TEST_EN
  localparam int RCT_W = $clog2(RCT_CUTOFF + 1);

  logic [RCT_W-1:0] rct_cnt_q, rct_cnt_d;
  logic             rct_bit_q, rct_bit_d;
  logic             fail_q, fail_d;

  // Repetition count on raw bits; failure flushes in the same edge it is detected.
  always_comb begin
    rct_cnt_d = rct_cnt_q;
    rct_bit_d = rct_bit_q;
    fail_d    = fail_q;
    if (ent_valid) begin
      rct_bit_d = ent_bit;
      if (rct_cnt_q == '0 || ent_bit != rct_bit_q) rct_cnt_d = RCT_W'(1);
      else if (rct_cnt_q < RCT_W'(RCT_CUTOFF))     rct_cnt_d = rct_cnt_q + RCT_W'(1);
      if (rct_cnt_d == RCT_W'(RCT_CUTOFF)) fail_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rct_cnt_q <= '0;
      fail_q    <= 1'b0;
    end else begin
      rct_cnt_q <= rct_cnt_d;
      fail_q    <= fail_d;
    end
    rct_bit_q <= rct_bit_d;
  end

  assign flush       = fail_d;
  assign health_fail = fail_q;
`else
  assign flush       = 1'b0;
  assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_trng_word_source.sv
// Self-checking bench for trng_word_source: table of raw streams with expected words,
// a scoreboard of delivered words, and hand-written multi-cycle sequences.
module tb_trng_word_source;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ent_bit = 1'b0;
  logic        ent_valid = 1'b0;
  logic        trng_request = 1'b0;
  logic        trng_ready;
  logic [31:0] trng_data;
  logic [2:0]  fifo_level;
  logic        health_fail;

  always #5 clk = ~clk;

  trng_word_source #(
    .FIFO_DEPTH (4),
    .RCT_CUTOFF (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ent_bit      (ent_bit),
    .ent_valid    (ent_valid),
    .trng_request (trng_request),
    .trng_ready   (trng_ready),
    .trng_data    (trng_data),
    .fifo_level   (fifo_level),
    .health_fail  (health_fail)
  );

  typedef struct {
    logic [63:0] raw;   // raw bits, bit 0 sent first; pair i = (raw[2i], raw[2i+1])
    int          junk;  // insert a 00 and an 11 pair after every 'junk' data pairs (0 = none)
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  int          pulse_cnt = 0;
  int          rd_idx = 0;
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    if (trng_ready) begin
      got_q.push_back(trng_data);
      pulse_cnt <= pulse_cnt + 1;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ent_valid = 1'b1;
    ent_bit   = b;
    tick();
    ent_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    for (int i = 0; i < 32; i++) begin
      send_bit(v.raw[2*i]);
      send_bit(v.raw[2*i+1]);
      if (v.junk > 0 && ((i + 1) % v.junk) == 0 && i != 31) begin
        send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1);
      end
    end
    exp_q.push_back(v.exp);
  endtask

  task automatic sb_check(input string name);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got a word with none expected", name);
    end else begin
      e = exp_q.pop_front();
      if (rd_idx >= got_q.size()) begin
        errors++;
        $display("FAIL %s: got no word expected %h", name, e);
      end else begin
        if (got_q[rd_idx] !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", name, got_q[rd_idx], e);
        end
        rd_idx++;
      end
    end
  endtask

  task automatic serve_one(input string name);
    int waited = 0;
    trng_request = 1'b1;
    tick();
    check({name, " latency"}, {31'd0, trng_ready}, 32'd1);
    while (!trng_ready && waited < 8) begin
      tick();
      waited++;
    end
    trng_request = 1'b0;
    sb_check({name, " data"});
    tick();
    check({name, " gap"}, {31'd0, trng_ready}, 32'd0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    vecs[0] = '{raw: 64'h5555_5555_5555_5555, junk: 0, exp: 32'hFFFF_FFFF};
    vecs[1] = '{raw: 64'h9999_9999_9999_9999, junk: 0, exp: 32'h5555_5555};
    vecs[2] = '{raw: 64'h9999_9999_9999_9999, junk: 1, exp: 32'h5555_5555};
    vecs[3] = '{raw: 64'h6666_6666_6666_6666, junk: 3, exp: 32'hAAAA_AAAA};
    vecs[4] = '{raw: 64'h5555_5555_AAAA_AAAA, junk: 0, exp: 32'hFFFF_0000};
    vecs[5] = '{raw: 64'h6999_9999_9999_9995, junk: 2, exp: 32'h9555_5557};

    do_reset();
    check("reset ready", {31'd0, trng_ready}, 32'd0);
    check("reset data", trng_data, 32'd0);
    check("reset level", {29'd0, fifo_level}, 32'd0);
    check("reset health", {31'd0, health_fail}, 32'd0);

    for (int k = 0; k < 6; k++) begin
      send_vec(vecs[k]);
      check($sformatf("vec%0d level after pack", k), {29'd0, fifo_level}, 32'd1);
      serve_one($sformatf("vec%0d", k));
      check($sformatf("vec%0d level after serve", k), {29'd0, fifo_level}, 32'd0);
    end

    // Fill the FIFO, hold a fifth word in the packer, then drain with a held request.
    for (int k = 0; k < 4; k++) send_vec(vecs[k]);
    check("fill level 4", {29'd0, fifo_level}, 32'd4);
    send_vec(vecs[4]);
    check("held word not pushed", {29'd0, fifo_level}, 32'd4);
    p0 = pulse_cnt;
    trng_request = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check($sformatf("burst pulse c%0d", c), {31'd0, trng_ready}, {31'd0, (c % 3) == 1});
      if (c == 1) check("burst level after first pop", {29'd0, fifo_level}, 32'd3);
      if (c == 2) check("held word pushed", {29'd0, fifo_level}, 32'd4);
    end
    trng_request = 1'b0;
    repeat (3) tick();
    check("burst pulse count", pulse_cnt - p0, 32'd4);
    check("burst level remaining", {29'd0, fifo_level}, 32'd1);
    for (int k = 0; k < 4; k++) sb_check($sformatf("burst order %0d", k));
    serve_one("held word");
    check("held word drained", {29'd0, fifo_level}, 32'd0);

    // Request held on an empty FIFO: served as soon as the first word lands.
    p0 = pulse_cnt;
    trng_request = 1'b1;
    repeat (6) tick();
    check("empty request no pulse", pulse_cnt - p0, 32'd0);
    send_vec(vecs[3]);
    check("empty request pushed ready", {31'd0, trng_ready}, 32'd0);
    check("empty request pushed level", {29'd0, fifo_level}, 32'd1);
    tick();
    check("empty request pulse", {31'd0, trng_ready}, 32'd1);
    trng_request = 1'b0;
    sb_check("empty request data");
    tick();
    tick();

    // Long run of identical raw bits.
    do_reset();
    send_vec(vecs[0]);
    check("rct word buffered", {29'd0, fifo_level}, 32'd1);
    repeat (31) send_bit(1'b1);
    check("rct before cutoff", {31'd0, health_fail}, 32'd0);
    send_bit(1'b1);
`ifdef TRNG_HEALTH_TEST_EN
    check("rct fail at cutoff", {31'd0, health_fail}, 32'd1);
    check("rct flush level", {29'd0, fifo_level}, 32'd0);
    repeat (8) send_bit(1'b1);
    p0 = pulse_cnt;
    trng_request = 1'b1;
    repeat (6) tick();
    trng_request = 1'b0;
    check("rct no pulses", pulse_cnt - p0, 32'd0);
    check("rct sticky", {31'd0, health_fail}, 32'd1);
    exp_q.delete();
    do_reset();
    check("rct cleared by reset", {31'd0, health_fail}, 32'd0);
`else
    check("rct disabled no fail", {31'd0, health_fail}, 32'd0);
    check("rct disabled level", {29'd0, fifo_level}, 32'd1);
    repeat (8) send_bit(1'b1);
    serve_one("rct disabled");
    check("rct disabled still no fail", {31'd0, health_fail}, 32'd0);
`endif

    // Reset in the SERVE cycle discards the buffered state and a partial word.
    do_reset();
    send_vec(vecs[1]);
    repeat (10) begin
      send_bit(1'b1);
      send_bit(1'b0);
    end
    trng_request = 1'b1;
    tick();
    check("rst serve cycle ready", {31'd0, trng_ready}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    trng_request = 1'b0;
    check("rst after serve ready", {31'd0, trng_ready}, 32'd0);
    check("rst after serve data", trng_data, 32'd0);
    check("rst after serve level", {29'd0, fifo_level}, 32'd0);
    sb_check("served before reset");
    send_vec(vecs[5]);
    check("post reset level", {29'd0, fifo_level}, 32'd1);
    serve_one("post reset word");

    repeat (4) tick();
    check("no unexpected pulses", got_q.size(), rd_idx);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
